// File: rtl/huff_freq_counter.sv
// Byte-stream frequency table builder for huff_encoder: counts unique characters,
// then stable-sorts the table by ascending count and holds it until acknowledged.
module huff_freq_counter #(
  parameter int MAX_CHAR_COUNT = 5,
  parameter int CHAR_W         = 8,
  parameter int FREQ_W         = 3
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        in_valid,
  input  logic [CHAR_W-1:0]                           in_char,
  input  logic                                        in_last,
  output logic                                        in_ready,
  output logic [MAX_CHAR_COUNT-1:0][CHAR_W-1:0]       char_out,
  output logic [0:MAX_CHAR_COUNT-1][FREQ_W-1:0]       freq_out,
  output logic [$clog2(MAX_CHAR_COUNT+1)-1:0]         unique_count,
  output logic                                        overflow,
  output logic                                        saturated,
  output logic                                        done,
  input  logic                                        out_ack
);

  localparam int UW = $clog2(MAX_CHAR_COUNT + 1);
  localparam int PW = $clog2(MAX_CHAR_COUNT + 1);
  localparam logic [FREQ_W-1:0] FREQ_MAX  = '1;
  localparam logic [PW-1:0]     LAST_PASS = PW'(MAX_CHAR_COUNT);
  localparam logic [UW-1:0]     FULL_CNT  = UW'(MAX_CHAR_COUNT);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SORT    = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CHAR_W-1:0]   r_char     [MAX_CHAR_COUNT];
  logic [FREQ_W-1:0]   r_freq     [MAX_CHAR_COUNT];
  logic [CHAR_W-1:0]   w_char_nxt [MAX_CHAR_COUNT];
  logic [FREQ_W-1:0]   w_freq_nxt [MAX_CHAR_COUNT];
  logic [UW-1:0]       r_ucnt;
  logic [UW-1:0]       w_ucnt_nxt;
  logic [PW-1:0]       r_pass;
  logic [PW-1:0]       w_pass_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic                r_sat;
  logic                w_sat_nxt;
  logic [MAX_CHAR_COUNT-1:0] w_hit_vec;
  logic                w_hit;
  logic                w_accept;

  // Ready is also held low while reset is asserted, even though the state sits in COLLECT.
  assign in_ready = (r_state == S_COLLECT) && reset;
  assign w_accept = in_valid && in_ready;
  assign done     = (r_state == S_DONE);

  // Only slots below the valid count can match, so a 0x00 char never hits an empty slot.
  always_comb begin
    w_hit_vec = '0;
    for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
      w_hit_vec[k] = (UW'(k) < r_ucnt) && (r_char[k] == in_char);
    end
  end
  assign w_hit = |w_hit_vec;

  always_comb begin
    w_state_nxt = r_state;
    w_char_nxt  = r_char;
    w_freq_nxt  = r_freq;
    w_ucnt_nxt  = r_ucnt;
    w_pass_nxt  = r_pass;
    w_ovf_nxt   = r_ovf;
    w_sat_nxt   = r_sat;
    case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          if (w_hit) begin
            for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
              if (w_hit_vec[k]) begin
                if (r_freq[k] == FREQ_MAX) w_sat_nxt = 1'b1;
                else                       w_freq_nxt[k] = r_freq[k] + FREQ_W'(1);
              end
            end
          end else if (r_ucnt < FULL_CNT) begin
            for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
              if (UW'(k) == r_ucnt) begin
                w_char_nxt[k] = in_char;
                w_freq_nxt[k] = FREQ_W'(1);
              end
            end
            w_ucnt_nxt = r_ucnt + UW'(1);
          end else begin
            w_ovf_nxt = 1'b1;
          end
          if (in_last) begin
            w_state_nxt = S_SORT;
            w_pass_nxt  = '0;
          end
        end
      end
      S_SORT: begin
        if (r_pass == LAST_PASS) begin
          w_state_nxt = S_DONE;
        end else begin
          // Odd-even transposition; strict compare keeps equal counts in arrival order.
          for (int i = 0; i < MAX_CHAR_COUNT - 1; i++) begin
            if ((i[0] == r_pass[0]) && (UW'(i + 1) < r_ucnt) && (r_freq[i] > r_freq[i+1])) begin
              w_char_nxt[i]   = r_char[i+1];
              w_freq_nxt[i]   = r_freq[i+1];
              w_char_nxt[i+1] = r_char[i];
              w_freq_nxt[i+1] = r_freq[i];
            end
          end
          w_pass_nxt = r_pass + PW'(1);
        end
      end
      S_DONE: begin
        if (out_ack) begin
          for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
            w_char_nxt[k] = '0;
            w_freq_nxt[k] = '0;
          end
          w_ucnt_nxt  = '0;
          w_ovf_nxt   = 1'b0;
          w_sat_nxt   = 1'b0;
          w_pass_nxt  = '0;
          w_state_nxt = S_COLLECT;
        end
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_COLLECT;
      for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
        r_char[k] <= '0;
        r_freq[k] <= '0;
      end
      r_ucnt <= '0;
      r_pass <= '0;
      r_ovf  <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
        r_char[k] <= w_char_nxt[k];
        r_freq[k] <= w_freq_nxt[k];
      end
      r_ucnt <= w_ucnt_nxt;
      r_pass <= w_pass_nxt;
      r_ovf  <= w_ovf_nxt;
      r_sat  <= w_sat_nxt;
    end
  end

  always_comb begin
    char_out = '0;
    freq_out = '0;
    for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
      char_out[k] = r_char[k];
      freq_out[k] = r_freq[k];
    end
  end

  assign unique_count = r_ucnt;
  assign overflow     = r_ovf;
  assign saturated    = r_sat;

endmodule

// File: tb/tb_huff_freq_counter.sv
// Randomized bench for huff_freq_counter with a queue scoreboard fed by a message-level
// reference model and drained by a monitor on each rising edge of done.
module tb_huff_freq_counter;

  localparam int N  = 5;
  localparam int CW = 8;
  localparam int FW = 3;
  localparam int UW = 3;
  localparam int FMAX = (1 << FW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ack = 1'b0;
  logic [CW-1:0] in_char = '0;
  logic in_ready;
  logic [N-1:0][CW-1:0] char_out;
  logic [0:N-1][FW-1:0] freq_out;
  logic [UW-1:0] unique_count;
  logic overflow, saturated, done;

  typedef logic [7:0] msg_t [$];
  typedef struct packed {
    logic [N-1:0][CW-1:0] ch;
    logic [0:N-1][FW-1:0] fr;
    logic [UW-1:0]        uc;
    logic                 ovf;
    logic                 sat;
  } exp_t;

  exp_t sbq [$];
  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int last_n = 0;
  bit pend = 1'b0;
  bit prev_done = 1'b0;

  huff_freq_counter #(.MAX_CHAR_COUNT(N), .CHAR_W(CW), .FREQ_W(FW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char), .in_last(in_last),
    .in_ready(in_ready), .char_out(char_out), .freq_out(freq_out),
    .unique_count(unique_count), .overflow(overflow), .saturated(saturated),
    .done(done), .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: count in arrival order, then stable insertion sort on count.
  function automatic exp_t model(input msg_t m);
    exp_t e;
    logic [7:0] ch [N];
    int fr [N];
    int n;
    bit f;
    logic [7:0] tc;
    int tf;
    e = '0;
    n = 0;
    for (int i = 0; i < N; i++) begin ch[i] = 8'h00; fr[i] = 0; end
    foreach (m[i]) begin
      f = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (ch[j] == m[i]) begin
          f = 1'b1;
          if (fr[j] == FMAX) e.sat = 1'b1;
          else fr[j]++;
        end
      end
      if (!f) begin
        if (n < N) begin ch[n] = m[i]; fr[n] = 1; n++; end
        else e.ovf = 1'b1;
      end
    end
    for (int i = 1; i < n; i++) begin
      for (int k = i; k > 0 && fr[k-1] > fr[k]; k--) begin
        tc = ch[k]; ch[k] = ch[k-1]; ch[k-1] = tc;
        tf = fr[k]; fr[k] = fr[k-1]; fr[k-1] = tf;
      end
    end
    for (int i = 0; i < n; i++) begin
      e.ch[i] = ch[i];
      e.fr[i] = FW'(fr[i]);
    end
    e.uc = UW'(n);
    return e;
  endfunction

  // Monitor: pop and compare on each rising edge of done, including latency from last beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset) begin
        pend = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (in_valid && in_ready && in_last) begin
          last_n = ncyc;
          pend = 1'b1;
        end
        if (done && !prev_done) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("latency", pend ? 64'(ncyc - last_n) : 64'd0, 64'd7);
            chk("sb_unique_count", 64'(unique_count), 64'(e.uc));
            chk("sb_chars", 64'(char_out), 64'(e.ch));
            chk("sb_freqs", 64'(freq_out), 64'(e.fr));
            chk("sb_overflow", 64'(overflow), 64'(e.ovf));
            chk("sb_saturated", 64'(saturated), 64'(e.sat));
          end
          pend = 1'b0;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [7:0] c, input bit last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_char = c;
    in_last = last;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("beat_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_clear(input string nm);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_ready"}, 64'(in_ready), 64'd1);
    chk({nm, "_uc"}, 64'(unique_count), 64'd0);
    chk({nm, "_chars"}, 64'(char_out), 64'd0);
    chk({nm, "_freqs"}, 64'(freq_out), 64'd0);
    chk({nm, "_ovf"}, 64'(overflow), 64'd0);
    chk({nm, "_sat"}, 64'(saturated), 64'd0);
  endtask

  task automatic run_msg(input msg_t m, input bit hold, input bit gaps, input string nm);
    exp_t e;
    int t;
    e = model(m);
    sbq.push_back(e);
    foreach (m[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
      end
      send_beat(m[i], i == m.size() - 1);
    end
    in_last = 1'b0;
    if (hold) begin in_valid = 1'b1; in_char = 8'h55; end
    else in_valid = 1'b0;
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    chk({nm, "_ready_sort"}, 64'(in_ready), 64'd0);
    chk({nm, "_done_sort"}, 64'(done), 64'd0);
    t = 0;
    while (!done && t < 40) begin @(posedge clk); #1; t++; end
    chk({nm, "_done_timeout"}, 64'(done), 64'd1);
    if (hold) begin
      repeat (3) begin @(posedge clk); #1; end
      chk({nm, "_hold_ready"}, 64'(in_ready), 64'd0);
      chk({nm, "_hold_done"}, 64'(done), 64'd1);
      chk({nm, "_hold_uc"}, 64'(unique_count), 64'(e.uc));
      chk({nm, "_hold_chars"}, 64'(char_out), 64'(e.ch));
      chk({nm, "_hold_freqs"}, 64'(freq_out), 64'(e.fr));
    end
    out_ack = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ack = 1'b0;
    chk_clear({nm, "_ack"});
  endtask

  function automatic msg_t str2msg(input string s);
    msg_t m;
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    return m;
  endfunction

  initial begin
    msg_t m;
    int len;
    int r;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_uc", 64'(unique_count), 64'd0);
    chk("rst_chars", 64'(char_out), 64'd0);
    chk("rst_freqs", 64'(freq_out), 64'd0);
    chk("rst_flags", 64'({overflow, saturated}), 64'd0);
    #20;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    run_msg(str2msg("aabb"), 1'b0, 1'b0, "aabb");
    run_msg(str2msg("anusha"), 1'b0, 1'b0, "anusha");
    run_msg(str2msg("xxxxxxxxx"), 1'b0, 1'b0, "sat9x");
    run_msg(str2msg("abcdef"), 1'b1, 1'b0, "ovf_hold");
    run_msg(str2msg("~}|"), 1'b0, 1'b0, "second");
    run_msg(str2msg("q"), 1'b0, 1'b0, "single");

    m = str2msg("anusha");
    foreach (m[i]) send_beat(m[i], i == m.size() - 1);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("abort_ready", 64'(in_ready), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_uc", 64'(unique_count), 64'd0);
    chk("abort_chars", 64'(char_out), 64'd0);
    chk("abort_freqs", 64'(freq_out), 64'd0);
    #12;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_clear("abort_release");
    run_msg(str2msg("zzyx"), 1'b0, 1'b0, "after_abort");

    for (int n = 0; n < 25; n++) begin
      m = {};
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 6);
        m.push_back((r == 0) ? 8'h00 : 8'(8'h60 + r));
      end
      run_msg(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/huff_freq_counter.md
Name: huff_freq_counter

Overview:
Upstream front-end of huff_encoder. Accepts a byte stream, one character per beat, and builds the table of unique characters with their occurrence counts. At end of message it sorts the table by ascending frequency (stable) and presents it as the data_in/freq_in arrays for huff_encoder, holding it with done high until acknowledged.

Parameters:
MAX_CHAR_COUNT, 5, number of table slots (max unique characters)
CHAR_W, 8, character width in bits
FREQ_W, 3, frequency counter width in bits (saturating)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
in_valid  input  1  in_char/in_last valid this cycle
in_char  input  CHAR_W  input character
in_last  input  1  marks final character of message
in_ready  output  1  block accepts a beat (beat accepted = in_valid & in_ready)
char_out  output  MAX_CHAR_COUNT*CHAR_W  packed [MAX_CHAR_COUNT-1:0][CHAR_W-1:0]; slot i character
freq_out  output  MAX_CHAR_COUNT*FREQ_W  packed [0:MAX_CHAR_COUNT-1][FREQ_W-1:0]; slot i count
unique_count  output  $clog2(MAX_CHAR_COUNT+1)  number of valid slots
overflow  output  1  sticky: a new unique character was dropped because the table was full
saturated  output  1  sticky: a count hit 2^FREQ_W-1 and a further hit was lost
done  output  1  table final and sorted
out_ack  input  1  consumer has taken the table; clears it and restarts

Behaviour:
- Reset (reset=0, async): state COLLECT; all slots char=0, freq=0; unique_count=0; overflow=0, saturated=0, done=0; in_ready=0 while reset is low.
- in_ready = (state==COLLECT). It is combinational from state only and never depends on in_valid.
- COLLECT, accepted beat:
  - in_char matches slot k, k<unique_count: freq[k]++. If freq[k] is already max, hold it and set saturated.
  - No match and unique_count<MAX_CHAR_COUNT: write slot[unique_count] with char=in_char, freq=1; unique_count++.
  - No match and table full: drop the character; set overflow.
  - Match search covers valid slots only. A char of 0x00 is legal and must not match empty slots.
  - in_last on an accepted beat: the update above is applied, then state goes to SORT on the same edge.
  - in_valid with in_last=0 and no other activity: counting continues.
- SORT: runs exactly MAX_CHAR_COUNT cycles of odd-even transposition, tracked by a pass counter.
  - Pass p even: compare pairs (0,1),(2,3),…
  - Pass p odd: compare pairs (1,2),(3,4),…
  - Swap char+freq of a pair only if both indices are < unique_count and freq[lo] > freq[hi] (strict compare, so ties keep arrival order and the sort is stable).
  - Input beats are not accepted (in_ready=0).
  - After the last pass, go to DONE.
- DONE: done=1. Outputs are frozen; in_ready=0.
  - out_ack=1: on the next edge clear all slots, unique_count, overflow, saturated and done, and return to COLLECT.
  - out_ack is ignored in COLLECT and SORT.
- Latency: if in_last is accepted at edge E, done is high after edge E+MAX_CHAR_COUNT+1. With default parameters that is 6 edges.
- Outputs in COLLECT/SORT show the internal table; they are valid for consumption only while done=1.
- Unused slots (index ≥ unique_count) always read char=0, freq=0. Sorted valid entries occupy slots 0..unique_count-1, lowest frequency at slot 0.
- Reset asserted mid-COLLECT or mid-SORT aborts the operation and returns to reset values. No partial table survives.
- A message of one character is legal: unique_count=1, no swaps, done after latency.
- There is no empty message, because in_last always carries a character.

Test Plan:
- Stream 'a','a','b','b'(last), in_valid continuous → done 6 edges after last; unique_count=2; slots: 'a'/2, 'b'/2 (tie keeps order); slots 2-4 zero; overflow=0.
- Stream "anusha" (last on final 'a') → unique_count=5; sorted slots 'n'/1,'u'/1,'s'/1,'h'/1,'a'/2.
- Nine 'x' beats, last on ninth → unique_count=1; freq[0]=7; saturated=1; overflow=0.
- Stream "abcdef" → slots 'a'..'e' each freq 1; 'f' dropped; overflow=1; unique_count=5.
- Hold in_valid=1 with data through SORT/DONE → in_ready=0 and table unchanged. out_ack pulse → next edge: done=0, table cleared, in_ready=1. Second message "~}|" then gives unique_count=3, each freq 1, original order.
- Assert reset during SORT pass 2 after "anusha" → all outputs zero immediately; after release, in_ready=1 and a fresh message processes normally.
